idct8_transpose: RTL and testbench

- Sits between the first (row) and second (column) pass of the 8-point IDCT datapath.
- Accepts one 8-coefficient row per cycle from the row-pass IDCT8 output and applies the inter-pass rounding shift and saturation.
- Stores rows in a ping-pong 8x8 buffer and emits the transposed block one column per cycle, ready to feed data_in_1..8 of the column-pass IDCT8.

---
 rtl/idct_pkg.sv | 39 +++
 rtl/idct_round_sat.sv | 19 +
 rtl/idct8_transpose.sv | 135 +++++++++++++
 tb/tb_idct8_transpose.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared definitions for the two-pass IDCT8 datapath: default widths,
// transpose-buffer bank status encoding and the inter-pass round/saturate.
package idct_pkg;

    localparam int unsigned IDCT_DATA_W = 25;
    localparam int unsigned IDCT_SHIFT  = 7;
    localparam int unsigned IDCT_OUT_W  = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_status_t;

    // Computed at 64 bits, a superset of the DATA_W+1 headroom needed for the add.
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] x,
        input int unsigned        shift,
        input int unsigned        out_w
    );
        logic signed [63:0] sum;
        logic signed [63:0] q;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = x + (64'sd1 <<< (shift - 1));
        q   = sum >>> shift;
        hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (out_w - 1));
        if (q > hi) begin
            return hi;
        end
        if (q < lo) begin
            return lo;
        end
        return q;
    endfunction

endpackage

// File: rtl/idct_round_sat.sv
// Single-element inter-pass conversion: rounding arithmetic right shift
// followed by saturation to OUT_W signed bits.
module idct_round_sat
    import idct_pkg::*;
#(
    parameter int unsigned DATA_W = IDCT_DATA_W,
    parameter int unsigned SHIFT  = IDCT_SHIFT,
    parameter int unsigned OUT_W  = IDCT_OUT_W
) (
    input  logic signed [DATA_W-1:0] x,
    output logic signed [OUT_W-1:0]  y
);

    logic signed [63:0] x_ext;

    assign x_ext = {{(64 - DATA_W){x[DATA_W-1]}}, x};
    assign y     = OUT_W'(round_sat(x_ext, SHIFT, OUT_W));

endmodule

// File: rtl/idct8_transpose.sv
// Inter-pass transpose for the IDCT8: rows in (rounded and saturated),
// columns out, through a two-bank ping-pong 8x8 buffer.
module idct8_transpose
    import idct_pkg::*;
#(
    parameter int unsigned DATA_W = IDCT_DATA_W,
    parameter int unsigned SHIFT  = IDCT_SHIFT,
    parameter int unsigned OUT_W  = IDCT_OUT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] data_in_1,
    input  logic signed [DATA_W-1:0] data_in_2,
    input  logic signed [DATA_W-1:0] data_in_3,
    input  logic signed [DATA_W-1:0] data_in_4,
    input  logic signed [DATA_W-1:0] data_in_5,
    input  logic signed [DATA_W-1:0] data_in_6,
    input  logic signed [DATA_W-1:0] data_in_7,
    input  logic signed [DATA_W-1:0] data_in_8,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  data_out_1,
    output logic signed [OUT_W-1:0]  data_out_2,
    output logic signed [OUT_W-1:0]  data_out_3,
    output logic signed [OUT_W-1:0]  data_out_4,
    output logic signed [OUT_W-1:0]  data_out_5,
    output logic signed [OUT_W-1:0]  data_out_6,
    output logic signed [OUT_W-1:0]  data_out_7,
    output logic signed [OUT_W-1:0]  data_out_8,
    output logic                     out_first,
    output logic                     out_last
);

    logic signed [DATA_W-1:0] din  [8];
    logic signed [OUT_W-1:0]  conv [8];
    logic signed [OUT_W-1:0]  dout [8];
    logic [OUT_W-1:0]         mem  [2][8][8];

    bank_status_t status [2];
    logic         wr_bank;
    logic         rd_bank;
    logic [2:0]   row_cnt;
    logic [2:0]   col_cnt;
    logic         wr_en;
    logic         rd_en;

    assign din[0] = data_in_1;
    assign din[1] = data_in_2;
    assign din[2] = data_in_3;
    assign din[3] = data_in_4;
    assign din[4] = data_in_5;
    assign din[5] = data_in_6;
    assign din[6] = data_in_7;
    assign din[7] = data_in_8;

    for (genvar i = 0; i < 8; i++) begin : g_conv
        idct_round_sat #(
            .DATA_W(DATA_W),
            .SHIFT (SHIFT),
            .OUT_W (OUT_W)
        ) u_round_sat (
            .x(din[i]),
            .y(conv[i])
        );
    end

    assign in_ready  = (status[wr_bank] == BANK_EMPTY) || (status[wr_bank] == BANK_FILLING);
    assign out_valid = (status[rd_bank] == BANK_FULL)  || (status[rd_bank] == BANK_DRAINING);
    assign wr_en     = in_valid && in_ready;
    assign rd_en     = out_valid && out_ready;

    // Storage carries no reset; a stale bank is never visible because status gates it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned c = 0; c < 8; c++) begin
                mem[wr_bank][row_cnt][c[2:0]] <= conv[c[2:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status[0] <= BANK_EMPTY;
            status[1] <= BANK_EMPTY;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            row_cnt   <= '0;
            col_cnt   <= '0;
        end else begin
            // Write and read always target different banks, so both updates are independent.
            if (wr_en) begin
                if (row_cnt == 3'd7) begin
                    status[wr_bank] <= BANK_FULL;
                    wr_bank         <= ~wr_bank;
                end else begin
                    status[wr_bank] <= BANK_FILLING;
                end
                row_cnt <= row_cnt + 3'd1;
            end
            if (rd_en) begin
                if (col_cnt == 3'd7) begin
                    status[rd_bank] <= BANK_EMPTY;
                    rd_bank         <= ~rd_bank;
                end else begin
                    status[rd_bank] <= BANK_DRAINING;
                end
                col_cnt <= col_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < 8; k++) begin
            dout[k[2:0]] = '0;
            if (out_valid) begin
                dout[k[2:0]] = mem[rd_bank][k[2:0]][col_cnt];
            end
        end
    end

    assign data_out_1 = dout[0];
    assign data_out_2 = dout[1];
    assign data_out_3 = dout[2];
    assign data_out_4 = dout[3];
    assign data_out_5 = dout[4];
    assign data_out_6 = dout[5];
    assign data_out_7 = dout[6];
    assign data_out_8 = dout[7];

    assign out_first = out_valid && (col_cnt == 3'd0);
    assign out_last  = out_valid && (col_cnt == 3'd7);

endmodule

// File: tb/tb_idct8_transpose.sv
// Self-checking bench for idct8_transpose against a queue-based transpose model.
module tb_idct8_transpose;

    localparam int DW = 25;
    localparam int SH = 7;
    localparam int OW = 16;
    localparam longint HALF = longint'(1) << (SH - 1);
    localparam longint DIV  = longint'(1) << SH;
    localparam longint MAXV = (longint'(1) << (OW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (OW - 1));

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, out_first, out_last;
    logic signed [DW-1:0] din  [8];
    logic signed [OW-1:0] dout [8];

    int n_cmp = 0;
    int n_bad = 0;

    // Model: flat queue of pending output columns (8 ints each) plus the partial block.
    int colv [$];
    int rowbuf [8][8];
    int nrows = 0;
    int head_col = 0;

    idct8_transpose #(.DATA_W(DW), .SHIFT(SH), .OUT_W(OW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .data_in_1(din[0]), .data_in_2(din[1]), .data_in_3(din[2]), .data_in_4(din[3]),
        .data_in_5(din[4]), .data_in_6(din[5]), .data_in_7(din[6]), .data_in_8(din[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out_1(dout[0]), .data_out_2(dout[1]), .data_out_3(dout[2]), .data_out_4(dout[3]),
        .data_out_5(dout[4]), .data_out_6(dout[5]), .data_out_7(dout[6]), .data_out_8(dout[7]),
        .out_first(out_first), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic int conv(input longint x);
        longint s, q;
        s = x + HALF;
        if (s >= 0) q = s / DIV;
        else        q = -((-s + DIV - 1) / DIV);
        if (q > MAXV) q = MAXV;
        if (q < MINV) q = MINV;
        return int'(q);
    endfunction

    function automatic void model_reset();
        colv.delete();
        nrows = 0;
        head_col = 0;
    endfunction

    function automatic void model_push();
        for (int c = 0; c < 8; c++) rowbuf[nrows][c] = conv(longint'(din[c]));
        nrows++;
        if (nrows == 8) begin
            for (int c = 0; c < 8; c++)
                for (int k = 0; k < 8; k++) colv.push_back(rowbuf[k][c]);
            nrows = 0;
        end
    endfunction

    function automatic void model_pop();
        repeat (8) void'(colv.pop_front());
        head_col = (head_col + 1) % 8;
    endfunction

    function automatic bit exp_in_ready();
        return (((colv.size() / 8) + 7) / 8) < 2;
    endfunction

    function automatic logic signed [DW-1:0] rand_sample();
        int v;
        if ($urandom_range(3) == 0) return DW'($urandom);
        v = int'($urandom_range(2097151)) - 1048576;
        return DW'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if ({out_first, out_last} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b%b want 00", out_first, out_last); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (dout[k] !== 16'sd0) begin n_bad++; $display("FAIL reset_dout%0d: got %0d want 0", k + 1, dout[k]); end
        end
        tick();
        tick();
        reset = 1'b1;
        model_reset();
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_ramp();
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1;
            for (int c = 0; c < 8; c++) din[c] = DW'(128 * (10 * r + c));
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ramp_in_ready row%0d: got %b want 1", r, in_ready); end
            model_push();
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ramp_out_valid col%0d: got %b want 1", c, out_valid); end
            n_cmp++; if (out_first !== (c == 0)) begin n_bad++; $display("FAIL ramp_first col%0d: got %b want %b", c, out_first, c == 0); end
            n_cmp++; if (out_last !== (c == 7)) begin n_bad++; $display("FAIL ramp_last col%0d: got %b want %b", c, out_last, c == 7); end
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if (dout[k] !== 10 * k + c) begin n_bad++; $display("FAIL ramp_col%0d_dout%0d: got %0d want %0d", c, k + 1, dout[k], 10 * k + c); end
            end
            model_pop();
            tick();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ramp_drained_valid: got %b want 0", out_valid); end
    endtask

    // Random traffic with full model checking every cycle; runs until nrows sent and all columns drained.
    task automatic test_traffic(input string name, input int nr, input int pv, input int pr,
                                input int maxcyc, output int cycles);
        int  sent = 0;
        int  cyc = 0;
        bit  pending = 1'b0;
        bit  erdy, evld;
        while ((sent < nr || colv.size() != 0) && cyc < maxcyc) begin
            if (!pending) begin
                in_valid = (sent < nr) && ($urandom_range(99) < pv);
                for (int c = 0; c < 8; c++) din[c] = rand_sample();
            end
            out_ready = $urandom_range(99) < pr;
            erdy = exp_in_ready();
            evld = colv.size() != 0;
            n_cmp++; if (in_ready !== erdy) begin n_bad++; $display("FAIL %s_in_ready cyc%0d: got %b want %b", name, cyc, in_ready, erdy); end
            n_cmp++; if (out_valid !== evld) begin n_bad++; $display("FAIL %s_out_valid cyc%0d: got %b want %b", name, cyc, out_valid, evld); end
            n_cmp++; if (out_first !== (evld && head_col == 0)) begin n_bad++; $display("FAIL %s_first cyc%0d: got %b want %b", name, cyc, out_first, evld && head_col == 0); end
            n_cmp++; if (out_last !== (evld && head_col == 7)) begin n_bad++; $display("FAIL %s_last cyc%0d: got %b want %b", name, cyc, out_last, evld && head_col == 7); end
            for (int k = 0; k < 8; k++) begin
                int e;
                e = evld ? colv[k] : 0;
                n_cmp++;
                if (dout[k] !== e) begin n_bad++; $display("FAIL %s_dout%0d cyc%0d: got %0d want %0d", name, k + 1, cyc, dout[k], e); end
            end
            if (in_valid && erdy) begin
                model_push();
                sent++;
                pending = 1'b0;
            end else begin
                pending = in_valid;
            end
            if (out_ready && evld) model_pop();
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        cycles = cyc;
        n_cmp++;
        if (sent < nr || colv.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: sent %0d of %0d rows, %0d columns left, want all drained", name, sent, nr, colv.size() / 8);
        end
    endtask

    task automatic test_rounding();
        int vals [4] = '{8976, -8976, 64, -65};
        int exps [4] = '{70, -70, 1, -1};
        int cyc;
        out_ready = 1'b0;
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1;
            for (int c = 0; c < 8; c++) din[c] = '0;
            if (r < 4) din[0] = DW'(vals[r]);
            model_push();
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (out_first !== 1'b1) begin n_bad++; $display("FAIL round_first: got %b want 1", out_first); end
        for (int k = 0; k < 8; k++) begin
            int e;
            e = (k < 4) ? exps[k] : 0;
            n_cmp++;
            if (dout[k] !== e) begin n_bad++; $display("FAIL round_dout%0d: got %0d want %0d", k + 1, dout[k], e); end
        end
        test_traffic("round_drain", 0, 0, 100, 40, cyc);
    endtask

    task automatic test_saturation();
        int cyc;
        out_ready = 1'b0;
        for (int r = 0; r < 8; r++) begin
            in_valid = 1'b1;
            for (int c = 0; c < 8; c++) din[c] = rand_sample();
            if (r == 0) begin
                din[0] = DW'(5000000);
                din[1] = DW'(-5000000);
            end
            model_push();
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (dout[0] !== 16'sd32767) begin n_bad++; $display("FAIL sat_pos: got %0d want 32767", dout[0]); end
        out_ready = 1'b1;
        model_pop();
        tick();
        n_cmp++; if (dout[0] !== -16'sd32768) begin n_bad++; $display("FAIL sat_neg: got %0d want -32768", dout[0]); end
        test_traffic("sat_drain", 0, 0, 100, 40, cyc);
    endtask

    task automatic test_backpressure();
        int cyc;
        out_ready = 1'b0;
        for (int r = 0; r < 16; r++) begin
            in_valid = 1'b1;
            for (int c = 0; c < 8; c++) din[c] = rand_sample();
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_in_ready row%0d: got %b want 1", r, in_ready); end
            model_push();
            tick();
        end
        for (int c = 0; c < 8; c++) din[c] = rand_sample();
        for (int h = 0; h < 3; h++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_in_ready hold%0d: got %b want 0", h, in_ready); end
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_full_out_valid hold%0d: got %b want 1", h, out_valid); end
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if (dout[k] !== colv[k]) begin n_bad++; $display("FAIL bp_stable_dout%0d hold%0d: got %0d want %0d", k + 1, h, dout[k], colv[k]); end
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_drainA_in_ready col%0d: got %b want 0", c, in_ready); end
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if (dout[k] !== colv[k]) begin n_bad++; $display("FAIL bp_A_col%0d_dout%0d: got %0d want %0d", c, k + 1, dout[k], colv[k]); end
            end
            model_pop();
            tick();
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_freed_in_ready: got %b want 1", in_ready); end
        test_traffic("bp_drainB", 0, 0, 100, 40, cyc);
    endtask

    task automatic test_streaming();
        int cyc;
        test_traffic("stream", 32, 100, 100, 100, cyc);
        n_cmp++; if (cyc !== 40) begin n_bad++; $display("FAIL stream_cycles: got %0d want 40", cyc); end
    endtask

    task automatic test_random();
        int cyc;
        test_traffic("random", 40, 60, 50, 800, cyc);
    endtask

    task automatic test_reset_mid();
        int cyc;
        out_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            in_valid = 1'b1;
            for (int c = 0; c < 8; c++) din[c] = rand_sample();
            model_push();
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (dout[k] !== 16'sd0) begin n_bad++; $display("FAIL midrst_dout%0d: got %0d want 0", k + 1, dout[k]); end
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        test_traffic("fresh", 8, 100, 100, 40, cyc);
    endtask

    initial begin
        for (int c = 0; c < 8; c++) din[c] = '0;
        test_reset();
        test_ramp();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_streaming();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
